// File: rtl/nn_classification_host_ctrl_if.sv
// Signal bundle between the host controller and its environment: command/status,
// input stream, xij/wb BRAM write ports, core handshake, xout read port, output stream.
interface nn_classification_host_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              cmd_go;
    logic              busy;
    logic              err_timeout;
    logic              s_valid;
    logic [15:0]       s_data;
    logic              s_ready;
    logic              xij_ena;
    logic [7:0]        xij_wea;
    logic [ADDR_W-1:0] xij_addra;
    logic [63:0]       xij_dina;
    logic              wb_ena;
    logic [7:0]        wb_wea;
    logic [ADDR_W-1:0] wb_addra;
    logic [63:0]       wb_dina;
    logic              core_ready;
    logic              core_start;
    logic              core_done;
    logic              xout_enb;
    logic [ADDR_W-1:0] xout_addrb;
    logic [15:0]       xout_doutb;
    logic              m_valid;
    logic [15:0]       m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  cmd_go, s_valid, s_data, core_ready, core_done, xout_doutb, m_ready,
        output busy, err_timeout, s_ready,
        output xij_ena, xij_wea, xij_addra, xij_dina,
        output wb_ena, wb_wea, wb_addra, wb_dina,
        output core_start, xout_enb, xout_addrb, m_valid, m_data, m_last
    );

    modport slave (
        output cmd_go, s_valid, s_data, core_ready, core_done, xout_doutb, m_ready,
        input  busy, err_timeout, s_ready,
        input  xij_ena, xij_wea, xij_addra, xij_dina,
        input  wb_ena, wb_wea, wb_addra, wb_dina,
        input  core_start, xout_enb, xout_addrb, m_valid, m_data, m_last
    );
endinterface

// File: rtl/nn_classification_host_ctrl.sv
// Host controller for forward_nn_classification_bram: packs the 16-bit input stream into the
// xij/wb BRAMs, runs the core, then streams the xout results back out with backpressure.
module nn_classification_host_ctrl #(
    parameter int unsigned X_DEPTH     = 9,
    parameter int unsigned WB_DEPTH    = 10,
    parameter int unsigned OUT_DEPTH   = 4,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic                         clk,
    input logic                         rst_n,
    nn_classification_host_ctrl_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(X_DEPTH - 1);
    localparam logic [ADDR_W-1:0] WB_LAST  = ADDR_W'(WB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_DEPTH - 1);
    localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StLoadX, StLoadWb, StStart, StWait, StRdReq, StRdCap, StOut
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [47:0]       pack_q, pack_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic              busy_q, busy_d, err_q, err_d, s_ready_q, s_ready_d;
    logic              xij_ena_q, xij_ena_d, wb_ena_q, wb_ena_d;
    logic [7:0]        xij_wea_q, xij_wea_d, wb_wea_q, wb_wea_d;
    logic [ADDR_W-1:0] xij_addra_q, xij_addra_d, wb_addra_q, wb_addra_d;
    logic [63:0]       xij_dina_q, xij_dina_d, wb_dina_q, wb_dina_d;
    logic              core_start_q, core_start_d, xout_enb_q, xout_enb_d;
    logic [ADDR_W-1:0] xout_addrb_q, xout_addrb_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [15:0]       m_data_q, m_data_d;
    logic              accept;

    assign accept = bus.s_valid && s_ready_q;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        word_d       = word_q;
        pack_d       = pack_q;
        tcnt_d       = tcnt_q;
        rd_idx_d     = rd_idx_q;
        err_d        = err_q;
        s_ready_d    = s_ready_q;
        xij_ena_d    = 1'b0;
        xij_wea_d    = 8'h00;
        xij_addra_d  = xij_addra_q;
        xij_dina_d   = xij_dina_q;
        wb_ena_d     = 1'b0;
        wb_wea_d     = 8'h00;
        wb_addra_d   = wb_addra_q;
        wb_dina_d    = wb_dina_q;
        core_start_d = 1'b0;
        xout_enb_d   = 1'b0;
        xout_addrb_d = xout_addrb_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;

        unique case (state_q)
            StIdle: begin
                lane_d = '0;
                word_d = '0;
                tcnt_d = '0;
                if (bus.cmd_go) begin
                    state_d   = StLoadX;
                    err_d     = 1'b0;
                    s_ready_d = 1'b1;
                end
            end
            StLoadX, StLoadWb: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: pack_d[47:32] = bus.s_data;
                        2'd1: pack_d[31:16] = bus.s_data;
                        2'd2: pack_d[15:0]  = bus.s_data;
                        2'd3: begin
                            // Write lands next cycle while the next word is already accepted.
                            word_d = word_q + 1'b1;
                            if (state_q == StLoadX) begin
                                xij_ena_d   = 1'b1;
                                xij_wea_d   = 8'hFF;
                                xij_addra_d = word_q;
                                xij_dina_d  = {pack_q, bus.s_data};
                                if (word_q == X_LAST) begin
                                    state_d = StLoadWb;
                                    word_d  = '0;
                                end
                            end else begin
                                wb_ena_d   = 1'b1;
                                wb_wea_d   = 8'hFF;
                                wb_addra_d = word_q;
                                wb_dina_d  = {pack_q, bus.s_data};
                                if (word_q == WB_LAST) begin
                                    state_d   = StStart;
                                    s_ready_d = 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StStart: begin
                // First START cycle carries the final wb write, so the pulse lands after it.
                if (bus.core_ready) begin
                    core_start_d = 1'b1;
                    state_d      = StWait;
                    tcnt_d       = '0;
                end
            end
            StWait: begin
                if (bus.core_done) begin
                    state_d      = StRdReq;
                    rd_idx_d     = '0;
                    xout_enb_d   = 1'b1;
                    xout_addrb_d = '0;
                end else if (tcnt_q == T_LAST) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StRdReq: state_d = StRdCap;
            StRdCap: begin
                m_data_d  = bus.xout_doutb;
                m_valid_d = 1'b1;
                m_last_d  = (rd_idx_q == OUT_LAST);
                state_d   = StOut;
            end
            StOut: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        state_d = StIdle;
                    end else begin
                        rd_idx_d     = rd_idx_q + 1'b1;
                        xout_enb_d   = 1'b1;
                        xout_addrb_d = rd_idx_q + 1'b1;
                        state_d      = StRdReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lane_q       <= '0;
            word_q       <= '0;
            pack_q       <= '0;
            tcnt_q       <= '0;
            rd_idx_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            xij_ena_q    <= 1'b0;
            xij_wea_q    <= 8'h00;
            xij_addra_q  <= '0;
            xij_dina_q   <= '0;
            wb_ena_q     <= 1'b0;
            wb_wea_q     <= 8'h00;
            wb_addra_q   <= '0;
            wb_dina_q    <= '0;
            core_start_q <= 1'b0;
            xout_enb_q   <= 1'b0;
            xout_addrb_q <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            pack_q       <= pack_d;
            tcnt_q       <= tcnt_d;
            rd_idx_q     <= rd_idx_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            s_ready_q    <= s_ready_d;
            xij_ena_q    <= xij_ena_d;
            xij_wea_q    <= xij_wea_d;
            xij_addra_q  <= xij_addra_d;
            xij_dina_q   <= xij_dina_d;
            wb_ena_q     <= wb_ena_d;
            wb_wea_q     <= wb_wea_d;
            wb_addra_q   <= wb_addra_d;
            wb_dina_q    <= wb_dina_d;
            core_start_q <= core_start_d;
            xout_enb_q   <= xout_enb_d;
            xout_addrb_q <= xout_addrb_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
    assign bus.s_ready     = s_ready_q;
    assign bus.xij_ena     = xij_ena_q;
    assign bus.xij_wea     = xij_wea_q;
    assign bus.xij_addra   = xij_addra_q;
    assign bus.xij_dina    = xij_dina_q;
    assign bus.wb_ena      = wb_ena_q;
    assign bus.wb_wea      = wb_wea_q;
    assign bus.wb_addra    = wb_addra_q;
    assign bus.wb_dina     = wb_dina_q;
    assign bus.core_start  = core_start_q;
    assign bus.xout_enb    = xout_enb_q;
    assign bus.xout_addrb  = xout_addrb_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_last      = m_last_q;
endmodule
